// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Package     : spi_pkg
// Description : Shared constants and state encoding for the SPI trace-frame
//               scheduler and its strobe synchronisers.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // Data words per trace frame; fixed by the frame format.
    localparam int C_FRAME_WORDS = 8;

    // Flops in each SPI-to-clk strobe synchroniser chain.
    localparam int C_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_SENDING = 2'd2
    } sched_state_t;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_frame_scheduler_if.sv
`default_nettype none
// ============================================================================
// Interface   : spi_frame_scheduler_if
// Description : Upstream trace stream, transmitter word path and SPI-side
//               strobes of the frame scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_frame_scheduler_if;

    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] tx_word;
    logic        transmit;
    logic        sync;
    logic        tx_free_async;
    logic        frame_reset_async;
    logic [15:0] frames_sent;
    logic        overrun;

    modport master (
        output in_data,
        output in_valid,
        output tx_free_async,
        output frame_reset_async,
        input  in_ready,
        input  tx_word,
        input  transmit,
        input  sync,
        input  frames_sent,
        input  overrun
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  tx_free_async,
        input  frame_reset_async,
        output in_ready,
        output tx_word,
        output transmit,
        output sync,
        output frames_sent,
        output overrun
    );

endinterface : spi_frame_scheduler_if
`default_nettype wire

// File: rtl/cdc_pulse_sync.sv
`default_nettype none
// ============================================================================
// Module      : cdc_pulse_sync
// Description : Multi-flop synchroniser plus rising-edge detector; produces a
//               one-clk pulse three clk edges after an asynchronous rise.
// Revision    : 1.0 - initial release
// ============================================================================
module cdc_pulse_sync
    import spi_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_async,
    output logic      o_pulse
);

    logic [C_SYNC_STAGES-1:0] r_chain;
    logic                     r_prev;
    logic                     r_pulse;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= '0;
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_chain <= {r_chain[C_SYNC_STAGES-2:0], i_async};
            r_prev  <= r_chain[C_SYNC_STAGES-1];
            // Registered edge detect keeps the pulse glitch-free downstream.
            r_pulse <= r_chain[C_SYNC_STAGES-1] & ~r_prev;
        end
    end

    assign o_pulse = r_pulse;

endmodule : cdc_pulse_sync
`default_nettype wire

// File: rtl/spi_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : spi_frame_scheduler
// Description : Buffers 16-bit trace words and hands them to the SPI frame
//               transmitter one complete 8-word frame at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_frame_scheduler
    import spi_pkg::*;
#(
    parameter int DEPTH         = 64,
    parameter int SYNC_INTERVAL = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    spi_frame_scheduler_if.slave  bus
);

    localparam int c_AW  = $clog2(DEPTH);
    localparam int c_PW  = c_AW + 1;
    localparam int c_IW  = $clog2(C_FRAME_WORDS + 1);
    localparam int c_SCW = (SYNC_INTERVAL > 1) ? $clog2(SYNC_INTERVAL) : 1;

    logic [15:0]      r_mem [DEPTH];
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [c_PW-1:0]  r_base_ptr;
    logic [c_IW-1:0]  r_word_idx;
    sched_state_t     r_state;
    logic [15:0]      r_frames;
    logic [c_SCW-1:0] r_sync_cnt;
    logic             r_sync;
    logic             r_overrun;
    logic [15:0]      r_tx_word;

    logic             w_free_p;
    logic             w_reset_p;
    logic [c_PW-1:0]  w_used;
    logic             w_full;
    logic             w_wr_en;
    logic             w_frame_avail;
    logic [c_PW-1:0]  w_wr_ptr_nxt;
    logic [c_PW-1:0]  w_rd_inc;
    logic [c_PW-1:0]  w_used_after;
    logic [c_SCW-1:0] w_scnt_adv;

    sched_state_t     w_state_nxt;
    logic [c_PW-1:0]  w_rd_ptr_nxt;
    logic [c_PW-1:0]  w_base_nxt;
    logic [c_IW-1:0]  w_idx_nxt;
    logic [15:0]      w_frames_nxt;
    logic [c_SCW-1:0] w_scnt_nxt;

    cdc_pulse_sync u_free_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (bus.tx_free_async),
        .o_pulse (w_free_p)
    );

    cdc_pulse_sync u_reset_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (bus.frame_reset_async),
        .o_pulse (w_reset_p)
    );

    // Occupancy is measured from the frame base, so words of a frame in
    // flight stay protected until the whole frame has completed.
    assign w_used        = r_wr_ptr - r_base_ptr;
    assign w_full        = (w_used == c_PW'(DEPTH));
    assign w_wr_en       = bus.in_valid && !w_full;
    assign w_frame_avail = (w_used >= c_PW'(C_FRAME_WORDS));
    assign w_wr_ptr_nxt  = w_wr_en ? (r_wr_ptr + c_PW'(1)) : r_wr_ptr;
    assign w_rd_inc      = r_rd_ptr + c_PW'(1);
    assign w_used_after  = w_wr_ptr_nxt - w_rd_inc;
    assign w_scnt_adv    = (r_sync_cnt == c_SCW'(SYNC_INTERVAL - 1)) ?
                           '0 : (r_sync_cnt + c_SCW'(1));

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= bus.in_data;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_rd_ptr_nxt = r_rd_ptr;
        w_base_nxt   = r_base_ptr;
        w_idx_nxt    = r_word_idx;
        w_frames_nxt = r_frames;
        w_scnt_nxt   = r_sync_cnt;
        if (w_reset_p) begin
            // Host resync rewinds to the start of the unfinished frame.
            w_rd_ptr_nxt = r_base_ptr;
            w_idx_nxt    = '0;
            w_state_nxt  = w_frame_avail ? ST_ARMED : ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_frame_avail) begin
                        w_state_nxt = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (w_free_p) begin
                        w_rd_ptr_nxt = w_rd_inc;
                        w_idx_nxt    = c_IW'(1);
                        w_state_nxt  = ST_SENDING;
                    end
                end
                ST_SENDING: begin
                    if (w_free_p) begin
                        w_rd_ptr_nxt = w_rd_inc;
                        w_idx_nxt    = r_word_idx + c_IW'(1);
                        if (r_word_idx == c_IW'(C_FRAME_WORDS - 1)) begin
                            w_base_nxt   = w_rd_inc;
                            w_frames_nxt = r_frames + 16'd1;
                            w_scnt_nxt   = w_scnt_adv;
                            w_idx_nxt    = '0;
                            w_state_nxt  = (w_used_after >= c_PW'(C_FRAME_WORDS)) ?
                                           ST_ARMED : ST_IDLE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_base_ptr <= '0;
            r_word_idx <= '0;
            r_frames   <= '0;
            r_sync_cnt <= '0;
            r_sync     <= 1'b0;
            r_overrun  <= 1'b0;
            r_tx_word  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_base_ptr <= w_base_nxt;
            r_word_idx <= w_idx_nxt;
            r_frames   <= w_frames_nxt;
            r_sync_cnt <= w_scnt_nxt;
            r_sync     <= (w_scnt_nxt == '0);
            if (bus.in_valid && w_full) begin
                r_overrun <= 1'b1;
            end
            // An empty buffer presents zeros rather than stale RAM contents.
            r_tx_word  <= (r_rd_ptr != r_wr_ptr) ? r_mem[r_rd_ptr[c_AW-1:0]] : 16'h0000;
        end
    end

    assign bus.in_ready    = !w_full;
    assign bus.tx_word     = r_tx_word;
    assign bus.transmit    = (r_state != ST_IDLE);
    assign bus.sync        = r_sync;
    assign bus.frames_sent = r_frames;
    assign bus.overrun     = r_overrun;

endmodule : spi_frame_scheduler
`default_nettype wire

// File: tb/tb_spi_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_frame_scheduler
// Description : Directed self-checking bench for the SPI frame scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_frame_scheduler;

    localparam int DEPTH         = 16;
    localparam int SYNC_INTERVAL = 4;

    localparam logic [1:0] OP_PUSH = 2'd0;
    localparam logic [1:0] OP_FREE = 2'd1;
    localparam logic [1:0] OP_FRST = 2'd2;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] data;
        logic        exp_transmit;
        logic        exp_ready;
        logic        chk_word;
        logic [15:0] exp_word;
        logic [15:0] exp_frames;
    } vec_t;

    vec_t vecs[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    spi_frame_scheduler_if bus_if ();

    spi_frame_scheduler #(
        .DEPTH         (DEPTH),
        .SYNC_INTERVAL (SYNC_INTERVAL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [1:0] op, input logic [15:0] data, input logic tr,
                           input logic rdy, input logic chk, input logic [15:0] word,
                           input logic [15:0] frames);
        vec_t v;
        v.op = op; v.data = data; v.exp_transmit = tr; v.exp_ready = rdy;
        v.chk_word = chk; v.exp_word = word; v.exp_frames = frames;
        vecs.push_back(v);
    endtask

    task automatic push_word(input logic [15:0] d, input int settle);
        @(negedge clk);
        bus_if.in_data  = d;
        bus_if.in_valid = 1'b1;
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        repeat (settle) @(negedge clk);
    endtask

    task automatic pulse_free();
        @(negedge clk);
        bus_if.tx_free_async = 1'b1;
        repeat (4) @(negedge clk);
        bus_if.tx_free_async = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_frst();
        @(negedge clk);
        bus_if.frame_reset_async = 1'b1;
        repeat (4) @(negedge clk);
        bus_if.frame_reset_async = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus_if.in_valid = 1'b0;
        bus_if.tx_free_async = 1'b0;
        bus_if.frame_reset_async = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int accepted;

        bus_if.in_data = '0;
        bus_if.in_valid = 1'b0;
        bus_if.tx_free_async = 1'b0;
        bus_if.frame_reset_async = 1'b0;

        // First frame 0x0001..0x0008, then an idle strobe, then rewind frame.
        for (int i = 1; i <= 7; i++)
            add_vec(OP_PUSH, 16'(i), 1'b0, 1'b1, 1'b1, 16'h0001, 16'd0);
        add_vec(OP_PUSH, 16'h0008, 1'b1, 1'b1, 1'b1, 16'h0001, 16'd0);
        for (int i = 2; i <= 8; i++)
            add_vec(OP_FREE, 16'h0, 1'b1, 1'b1, 1'b1, 16'(i), 16'd0);
        add_vec(OP_FREE, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0, 16'd1);
        add_vec(OP_FREE, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0, 16'd1);
        for (int i = 0; i < 7; i++)
            add_vec(OP_PUSH, 16'h0011 + 16'(i), 1'b0, 1'b1, 1'b1, 16'h0011, 16'd1);
        add_vec(OP_PUSH, 16'h0018, 1'b1, 1'b1, 1'b1, 16'h0011, 16'd1);
        for (int i = 0; i < 3; i++)
            add_vec(OP_FREE, 16'h0, 1'b1, 1'b1, 1'b1, 16'h0012 + 16'(i), 16'd1);
        add_vec(OP_FRST, 16'h0, 1'b1, 1'b1, 1'b1, 16'h0011, 16'd1);
        for (int i = 0; i < 7; i++)
            add_vec(OP_FREE, 16'h0, 1'b1, 1'b1, 1'b1, 16'h0012 + 16'(i), 16'd1);
        add_vec(OP_FREE, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0, 16'd2);

        // Reset state, sampled while rst is still asserted.
        repeat (3) @(negedge clk);
        check("rst in_ready", 32'(bus_if.in_ready), 32'd1);
        check("rst tx_word", 32'(bus_if.tx_word), 32'd0);
        check("rst transmit", 32'(bus_if.transmit), 32'd0);
        check("rst sync", 32'(bus_if.sync), 32'd0);
        check("rst frames_sent", 32'(bus_if.frames_sent), 32'd0);
        check("rst overrun", 32'(bus_if.overrun), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            unique case (vecs[i].op)
                OP_PUSH: push_word(vecs[i].data, 2);
                OP_FREE: pulse_free();
                default: pulse_frst();
            endcase
            check($sformatf("vec%0d transmit", i), 32'(bus_if.transmit), 32'(vecs[i].exp_transmit));
            check($sformatf("vec%0d in_ready", i), 32'(bus_if.in_ready), 32'(vecs[i].exp_ready));
            check($sformatf("vec%0d frames_sent", i), 32'(bus_if.frames_sent), 32'(vecs[i].exp_frames));
            if (vecs[i].chk_word)
                check($sformatf("vec%0d tx_word", i), 32'(bus_if.tx_word), 32'(vecs[i].exp_word));
        end

        // Fill to full, provoke overrun, then free one frame.
        do_reset();
        accepted = 0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            if (bus_if.in_ready) begin
                push_word(16'h0100 + 16'(i), 0);
                accepted++;
            end
        end
        check("fill accepted", 32'(accepted), 32'(DEPTH));
        check("full in_ready", 32'(bus_if.in_ready), 32'd0);
        check("full overrun pre", 32'(bus_if.overrun), 32'd0);
        push_word(16'hDEAD, 1);
        check("full overrun", 32'(bus_if.overrun), 32'd1);
        check("full in_ready hold", 32'(bus_if.in_ready), 32'd0);
        for (int i = 0; i < 8; i++) pulse_free();
        check("drain in_ready", 32'(bus_if.in_ready), 32'd1);
        check("drain frames_sent", 32'(bus_if.frames_sent), 32'd1);
        check("drain transmit", 32'(bus_if.transmit), 32'd1);
        check("drain tx_word", 32'(bus_if.tx_word), 32'h0108);
        check("drain overrun sticky", 32'(bus_if.overrun), 32'd1);

        // Sync flag cadence over nine frames with a period of four.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            for (int w = 0; w < 8; w++) push_word(16'(k * 8 + w), 0);
            repeat (2) @(negedge clk);
            check($sformatf("sync before frame %0d", k + 1), 32'(bus_if.sync),
                  32'((k % SYNC_INTERVAL) == 0));
            for (int w = 0; w < 8; w++) pulse_free();
            check($sformatf("frames after frame %0d", k + 1), 32'(bus_if.frames_sent), 32'(k + 1));
            check($sformatf("sync after frame %0d", k + 1), 32'(bus_if.sync),
                  32'(((k + 1) % SYNC_INTERVAL) == 0));
        end

        // Reset in the middle of a frame.
        do_reset();
        for (int w = 0; w < 8; w++) push_word(16'h0A00 + 16'(w), 0);
        for (int w = 0; w < 5; w++) pulse_free();
        check("mid tx_word", 32'(bus_if.tx_word), 32'h0A05);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst in_ready", 32'(bus_if.in_ready), 32'd1);
        check("midrst tx_word", 32'(bus_if.tx_word), 32'd0);
        check("midrst transmit", 32'(bus_if.transmit), 32'd0);
        check("midrst sync", 32'(bus_if.sync), 32'd0);
        check("midrst frames_sent", 32'(bus_if.frames_sent), 32'd0);
        check("midrst overrun", 32'(bus_if.overrun), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("postrst transmit", 32'(bus_if.transmit), 32'd0);
        for (int w = 0; w < 7; w++) push_word(16'h0B00 + 16'(w), 0);
        repeat (2) @(negedge clk);
        check("postrst 7 words transmit", 32'(bus_if.transmit), 32'd0);
        push_word(16'h0B07, 2);
        check("postrst 8 words transmit", 32'(bus_if.transmit), 32'd1);
        check("postrst tx_word", 32'(bus_if.tx_word), 32'h0B00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_spi_frame_scheduler
`default_nettype wire

// File: doc/spi_frame_scheduler.md
Name: spi_frame_scheduler

Overview:
Feeds the SPI trace-frame transmitter with 16-bit trace words, one 8-word frame at a time. Trace words arrive from the upstream packet path on a valid/ready stream and are buffered in a local FIFO. The block raises transmit only when a complete frame is buffered. It advances the presented word on each transmitter word request, rewinds a partially sent frame when the host resynchronises, and schedules periodic sync flags. It runs entirely in clk; the two SPI-side strobes (word request, frame reset) are synchronised internally.

Parameters:
DEPTH, 64, buffer depth in 16-bit words; power of two, ≥16
FRAME_WORDS, 8, data words per frame; fixed by the frame format
SYNC_INTERVAL, 32, frames between sync flag assertions; ≥1

Ports:
clk  in  1  system clock; must be ≥4× SPI clock frequency
rst  in  1  synchronous, active-high reset
in_data  in  16  trace word from upstream
in_valid  in  1  in_data valid
in_ready  out  1  buffer can accept a word
tx_word  out  16  word presented to transmitter
transmit  out  1  a complete frame is ready for the next frame slot
sync  out  1  sync flag for the next frame header
tx_free_async  in  1  transmitter word-consumed strobe (SPI clock domain)
frame_reset_async  in  1  host frame-reset level/strobe (SPI clock domain)
frames_sent  out  16  count of completed real frames, wraps
overrun  out  1  sticky: in_valid seen while in_ready low

Behaviour:
- Reset values: in_ready=1, tx_word=0, transmit=0, sync=0, frames_sent=0, overrun=0. Pointers, frame counter and sync counter are cleared; buffer contents are don't-care.
- Pointers: wr_ptr, rd_ptr and frame_base_ptr are each log2(DEPTH)+1 bits wide; the extra bit is for full/empty detection.
  - used = wr_ptr - frame_base_ptr
  - full when used == DEPTH
  - in_ready = !full
- Write: an in_valid && in_ready cycle stores in_data at wr_ptr and increments wr_ptr. Writing while full is impossible; in_valid while full sets overrun (sticky until rst).
- Synchroniser: tx_free_async and frame_reset_async each pass through a 2-flop synchroniser followed by rising-edge detection, giving a 1-cycle pulse 3 clk after the edge. Name the pulses free_p and reset_p.
- States:
  - IDLE: transmit=0; tx_word shows buf[rd_ptr].
    - Go to ARMED when used ≥ FRAME_WORDS.
  - ARMED: transmit=1; word_idx=0.
    - First free_p: the transmitter has latched word 0. Increment rd_ptr and word_idx, then go to SENDING.
  - SENDING: each free_p increments rd_ptr and word_idx.
    - When word_idx reaches FRAME_WORDS: set frame_base_ptr = rd_ptr, increment frames_sent, advance the sync counter, then return to IDLE (or straight to ARMED if another frame is already buffered; decided in the same cycle).
- tx_word is registered from buf[rd_ptr] and is valid 1 clk after any rd_ptr change. It must be stable before the transmitter's next word boundary; with clk ≥4× SPI clock this holds, since words are 16 SPI bits apart.
- free_p in IDLE is ignored (empty frames carry zeros).
- reset_p in any state:
  - rd_ptr = frame_base_ptr, word_idx = 0
  - go to ARMED if used ≥ FRAME_WORDS, else IDLE
  - frames_sent unchanged
  - reset_p takes priority over a simultaneous free_p.
- The sync counter counts completed frames modulo SYNC_INTERVAL. sync=1 while the counter is 0 and stays 1 until the next frame completes.
- Simultaneous write and frame completion: used is computed from the updated pointers; no word is lost or duplicated.
- Freed space becomes visible to the writer only at frame completion (frame_base_ptr advance), so a rewind never reads overwritten data.

Decomposition:
- Shared package (spi_pkg): FRAME_WORDS constant, state enum (IDLE/ARMED/SENDING), sync synchroniser depth constant.
- One sub-module, cdc_pulse_sync: 2-flop synchroniser plus rising-edge detector, instantiated twice.
- Buffer RAM is an inferred array inside the block.

Test Plan:
1. Reset, push 7 words -> transmit stays 0. Push an 8th -> transmit=1 within 2 clk; tx_word=word0.
2. Push words 0x0001..0x0008, then pulse tx_free 8 times at SPI rate -> tx_word steps through 0x0002..0x0008. After the 8th pulse: frames_sent=1, transmit=0.
3. Push 8 words, send 3 tx_free pulses, then pulse frame_reset -> tx_word=0x0001 again, transmit=1. A full 8-pulse resend completes with frames_sent=1.
4. With no writes, push words until in_ready=0 (DEPTH words accepted) -> in_ready=0. Drive in_valid once more -> overrun=1. Complete one frame -> in_ready=1.
5. With SYNC_INTERVAL=4, send 9 frames -> sync=1 before frame 1, after frame 4 and after frame 8; 0 otherwise.
6. Assert rst mid-frame (after 5 pulses) -> all outputs return to reset values next cycle; buffer reads as empty.
